// File: rtl/host_cmd_pkg.sv
// Shared types and constants for the host command interface and its register file.
package host_cmd_pkg;

  typedef enum logic [1:0] {
    OP_ID     = 2'd0,
    OP_WRITE  = 2'd1,
    OP_READ   = 2'd2,
    OP_LAUNCH = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    REG_A = 2'd0,
    REG_B = 2'd1,
    REG_Y = 2'd2
  } reg_id_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [31:0] ID_MAGIC = 32'hdeadbeef;

endpackage

// File: rtl/host_cmd_regs.sv
// Operand/result registers a, b, y: host write port, read mux and core result capture.
module host_cmd_regs
  import host_cmd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_id,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              y_cap_en,
  input  logic [DATA_W-1:0] y_cap_data,
  input  logic [1:0]        rd_id,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b
);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] y_q, y_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    y_d = y_q;
    if (y_cap_en) begin
      y_d = y_cap_data;
    end
    if (wr_en) begin
      case (reg_id_e'(wr_id))
        REG_A:   a_d = wr_data;
        REG_B:   b_d = wr_data;
        REG_Y:   y_d = wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (reg_id_e'(rd_id))
      REG_A:   rd_data = a_q;
      REG_B:   rd_data = b_q;
      REG_Y:   rd_data = y_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      y_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      y_q <= y_d;
    end
  end

  assign a = a_q;
  assign b = b_q;

endmodule

// File: rtl/host_cmd_if.sv
// Host command front end for the accelerator: accepts ID/WRITE/READ/LAUNCH commands,
// drives the core operands and launch pulse, and returns one response per command.
module host_cmd_if
  import host_cmd_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_opcode,
  input  logic [31:0]       cmd_id,
  input  logic [31:0]       cmd_data,
  input  logic [31:0]       cmd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_error,
  output logic [DATA_W-1:0] acc_a,
  output logic [DATA_W-1:0] acc_b,
  output logic              acc_start,
  input  logic              acc_done,
  input  logic [DATA_W-1:0] acc_y
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic              acc_start_q, acc_start_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              wr_en;
  logic              y_cap_en;
  logic [DATA_W-1:0] rd_data;
  logic              accept;
  logic              id_ok;
  logic              addr_ok;

  assign accept  = cmd_valid && cmd_ready_q;
  assign id_ok   = (cmd_id < 32'd3);
  assign addr_ok = (cmd_addr == 32'd0);

  host_cmd_regs #(
    .DATA_W(DATA_W)
  ) u_regs (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_id      (cmd_id[1:0]),
    .wr_data    (cmd_data[DATA_W-1:0]),
    .y_cap_en   (y_cap_en),
    .y_cap_data (acc_y),
    .rd_id      (cmd_id[1:0]),
    .rd_data    (rd_data),
    .a          (acc_a),
    .b          (acc_b)
  );

  generate
    if (DATA_W < 32) begin : g_unused_data
      logic unused_data_bits;
      assign unused_data_bits = ^cmd_data[31:DATA_W];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    acc_start_d = 1'b0;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    y_cap_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Ready rises one cycle after entering IDLE, giving the mandatory idle gap.
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          if (cmd_opcode < 32'd4) begin
            case (opcode_e'(cmd_opcode[1:0]))
              OP_ID: begin
                rsp_data_d  = ID_MAGIC;
                rsp_error_d = 1'b0;
              end
              OP_WRITE: begin
                if (id_ok && addr_ok) begin
                  wr_en       = 1'b1;
                  rsp_error_d = 1'b0;
                end
              end
              OP_READ: begin
                if (id_ok && addr_ok) begin
                  rsp_data_d  = 32'(rd_data);
                  rsp_error_d = 1'b0;
                end
              end
              OP_LAUNCH: begin
                state_d     = ST_START;
                rsp_valid_d = 1'b0;
                rsp_error_d = 1'b0;
                acc_start_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (acc_done) begin
          y_cap_en    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'(acc_y);
          rsp_error_d = 1'b0;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_error_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      acc_start_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      acc_start_q <= acc_start_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign acc_start = acc_start_q;

endmodule

// File: tb/tb_host_cmd_if.sv
// Scoreboard bench for host_cmd_if: directed commands push expected responses, a monitor checks them.
module tb_host_cmd_if;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_opcode;
  logic [31:0]       cmd_id;
  logic [31:0]       cmd_data;
  logic [31:0]       cmd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_error;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;
  logic              acc_start;
  logic              acc_done;
  logic [DATA_W-1:0] acc_y;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  int m_vec  = 0;
  int m_fail = 0;

  logic              core_en = 1'b0;
  int                core_delay = 4;
  logic [DATA_W-1:0] core_y = '0;

  always #5 clock = ~clock;

  host_cmd_if #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_id    (cmd_id),
    .cmd_data  (cmd_data),
    .cmd_addr  (cmd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .acc_a     (acc_a),
    .acc_b     (acc_b),
    .acc_start (acc_start),
    .acc_done  (acc_done),
    .acc_y     (acc_y)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Issue one command; optionally push its expected response and check registered latency.
  task automatic send(input logic [31:0] op, input logic [31:0] id, input logic [31:0] data,
                      input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e,
                      input bit push, input bit lat);
    int waited;
    exp_t e;
    if (push) begin
      e.data = exp_d;
      e.err  = exp_e;
      sb_q.push_back(e);
    end
    cmd_opcode = op;
    cmd_id     = id;
    cmd_data   = data;
    cmd_addr   = addr;
    cmd_valid  = 1'b1;
    waited = 0;
    forever begin
      @(negedge clock);
      if (cmd_ready) break;
      waited++;
      if (waited > 50) break;
    end
    if (waited > 50) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      $display("cmd  op=%0d id=%0d data=%h addr=%0d", op, id, data, addr);
      if (lat) chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || rsp_valid) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  // Response monitor: a handshake is seen at the negedge preceding the accepting edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && rsp_valid && rsp_ready) begin
        m_vec++;
        if (sb_q.size() == 0) begin
          m_fail++;
          $display("FAIL unexpected_rsp: got data=%h err=%b required no response", rsp_data, rsp_error);
        end else begin
          e = sb_q.pop_front();
          if (rsp_data !== e.data || rsp_error !== e.err) begin
            m_fail++;
            $display("FAIL rsp: got data=%h err=%b required data=%h err=%b",
                     rsp_data, rsp_error, e.data, e.err);
          end else begin
            $display("rsp  data=%h err=%b", rsp_data, rsp_error);
          end
        end
      end
    end
  end

  // Core model: pulses acc_done with core_y a fixed number of edges after acc_start.
  initial begin
    acc_done = 1'b0;
    acc_y    = '0;
    forever begin
      @(negedge clock);
      if (core_en && acc_start) begin
        repeat (core_delay) @(posedge clock);
        #1;
        acc_done = 1'b1;
        acc_y    = core_y;
        @(posedge clock);
        #1;
        acc_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_id     = '0;
    cmd_data   = '0;
    cmd_addr   = '0;
    rsp_ready  = 1'b1;
    reset      = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_acc_a", 32'(acc_a), 32'd0);
    chk("rst_acc_start", 32'(acc_start), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge clock);
    #1;
    chk("ready_after_edge", 32'(cmd_ready), 32'd1);

    send(32'd0, 32'd0, 32'd0, 32'd0, 32'hdeadbeef, 1'b0, 1'b1, 1'b1);
    wait_idle();

    send(32'd1, 32'd0, 32'h0000_01A5, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    send(32'd1, 32'd1, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    send(32'd2, 32'd0, 32'd0, 32'd0, 32'h0000_00A5, 1'b0, 1'b1, 1'b1);
    wait_idle();
    chk("acc_a", 32'(acc_a), 32'h0000_00A5);
    chk("acc_b", 32'(acc_b), 32'h0000_0003);

    // Launch with a responsive core; id/addr/data are ignored on LAUNCH.
    core_en    = 1'b1;
    core_delay = 4;
    core_y     = 8'hA8;
    send(32'd3, 32'd5, 32'hFFFF, 32'd9, 32'h0000_00A8, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    chk("start_high", 32'(acc_start), 32'd1);
    @(negedge clock);
    chk("start_single", 32'(acc_start), 32'd0);
    wait_idle();
    send(32'd2, 32'd2, 32'd0, 32'd0, 32'h0000_00A8, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Launch whose done arrives long after the timeout.
    core_delay = 30;
    core_y     = 8'h55;
    send(32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    chk("start_high_to", 32'(acc_start), 32'd1);
    @(negedge clock);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
    wait_idle();
    repeat (30) @(posedge clock);
    #1;
    core_en = 1'b0;
    send(32'd2, 32'd2, 32'd0, 32'd0, 32'h0000_00A8, 1'b0, 1'b1, 1'b1);

    // Rejected commands leave the registers alone.
    send(32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    send(32'd1, 32'd0, 32'hFF, 32'd1, 32'd0, 1'b1, 1'b1, 1'b1);
    send(32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    wait_idle();
    chk("err_acc_a", 32'(acc_a), 32'h0000_00A5);
    chk("err_acc_b", 32'(acc_b), 32'h0000_0003);
    send(32'd2, 32'd2, 32'd0, 32'd0, 32'h0000_00A8, 1'b0, 1'b1, 1'b1);
    send(32'd1, 32'd2, 32'h3C, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    send(32'd2, 32'd2, 32'd0, 32'd0, 32'h0000_003C, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Backpressure: response must hold steady while rsp_ready is low.
    rsp_ready = 1'b0;
    send(32'd2, 32'd0, 32'd0, 32'd0, 32'h0000_00A5, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'h0000_00A5);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset asserted while waiting on a silent core: no response, registers cleared.
    send(32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    chk("mid_rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("mid_rst_acc_a", 32'(acc_a), 32'd0);
    chk("mid_rst_acc_b", 32'(acc_b), 32'd0);
    chk("mid_rst_acc_start", 32'(acc_start), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    send(32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    send(32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    wait_idle();
    repeat (5) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec + m_vec, n_fail + m_fail);
    $finish;
  end

endmodule
